// File: rtl/key_search_ctrl.sv
// ============================================================================
// key_search_ctrl : requests keys from the generator, launches decrypts and
// stops on the first passing key or on key-space exhaustion.
// Optional KEY_SEARCH_TIMEOUT_EN adds a WAIT_DEC watchdog and timeout_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_search_ctrl #(
  parameter int KEY_W = 24,
  parameter int ATT_W = 23
`ifdef KEY_SEARCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             key_req,
  input  logic             key_rdy,
  input  logic             key_space_done,
  input  logic [KEY_W-1:0] key_in,
  output logic             decrypt_start,
  output logic [KEY_W-1:0] decrypt_key,
  input  logic             decrypt_done,
  input  logic             decrypt_pass,
  output logic             busy,
  output logic             found,
  output logic [KEY_W-1:0] found_key,
  output logic             exhausted,
`ifdef KEY_SEARCH_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic [ATT_W-1:0] attempts
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_REQ       = 4'd1;
  localparam logic [3:0] S_WAIT_DROP = 4'd2;
  localparam logic [3:0] S_WAIT_KEY  = 4'd3;
  localparam logic [3:0] S_LAUNCH    = 4'd4;
  localparam logic [3:0] S_WAIT_DEC  = 4'd5;
  localparam logic [3:0] S_FOUND     = 4'd6;
  localparam logic [3:0] S_EXHAUSTED = 4'd7;
`ifdef KEY_SEARCH_TIMEOUT_EN
  localparam logic [3:0] S_ERROR     = 4'd8;
  localparam int         CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [3:0]       state_q, state_d;
  logic             key_req_q, key_req_d;
  logic             decrypt_start_q, decrypt_start_d;
  logic [KEY_W-1:0] decrypt_key_q, decrypt_key_d;
  logic             busy_q, busy_d;
  logic             found_q, found_d;
  logic [KEY_W-1:0] found_key_q, found_key_d;
  logic             exhausted_q, exhausted_d;
  logic [ATT_W-1:0] attempts_q, attempts_d;
  logic             last_key_q, last_key_d;
  logic             go_clear, capture, dec_end;
`ifdef KEY_SEARCH_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      key_req_q       <= 1'b0;
      decrypt_start_q <= 1'b0;
      decrypt_key_q   <= '0;
      busy_q          <= 1'b0;
      found_q         <= 1'b0;
      found_key_q     <= '0;
      exhausted_q     <= 1'b0;
      attempts_q      <= '0;
      last_key_q      <= 1'b0;
`ifdef KEY_SEARCH_TIMEOUT_EN
      tmo_cnt_q       <= '0;
      timeout_err_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      key_req_q       <= key_req_d;
      decrypt_start_q <= decrypt_start_d;
      decrypt_key_q   <= decrypt_key_d;
      busy_q          <= busy_d;
      found_q         <= found_d;
      found_key_q     <= found_key_d;
      exhausted_q     <= exhausted_d;
      attempts_q      <= attempts_d;
      last_key_q      <= last_key_d;
`ifdef KEY_SEARCH_TIMEOUT_EN
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_err_q   <= timeout_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: if (go) state_d = S_REQ;
      // key_req is raised on entry to REQ, so its pulse cycle is the exit cycle
      S_REQ: begin
        if (key_space_done) state_d = S_EXHAUSTED;
        else if (key_req_q) state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: if (!key_rdy) state_d = S_WAIT_KEY;
      S_WAIT_KEY:  if (key_rdy || key_space_done) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_DEC;
      S_WAIT_DEC: begin
        if (decrypt_done) begin
          if (decrypt_pass)    state_d = S_FOUND;
          else if (last_key_q) state_d = S_EXHAUSTED;
          else                 state_d = S_REQ;
        end
`ifdef KEY_SEARCH_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) state_d = S_ERROR;
`endif
      end
`ifdef KEY_SEARCH_TIMEOUT_EN
      S_ERROR: state_d = S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    go_clear = go && (state_q == S_IDLE || state_q == S_FOUND || state_q == S_EXHAUSTED);
    capture  = (state_q == S_WAIT_KEY) && (state_d == S_LAUNCH);
    dec_end  = (state_q == S_WAIT_DEC) && decrypt_done;

    key_req_d       = (state_d == S_REQ) && !key_req_q && key_rdy && !key_space_done;
    decrypt_start_d = capture;
    decrypt_key_d   = capture ? key_in : decrypt_key_q;
    busy_d          = !(state_d == S_IDLE || state_d == S_FOUND || state_d == S_EXHAUSTED);
`ifdef KEY_SEARCH_TIMEOUT_EN
    if (state_d == S_ERROR) busy_d = 1'b0;
`endif

    last_key_d = last_key_q;
    if (go_clear)     last_key_d = 1'b0;
    else if (capture) last_key_d = key_space_done;

    found_d     = found_q;
    found_key_d = found_key_q;
    if (go_clear) found_d = 1'b0;
    else if (dec_end && decrypt_pass) begin
      found_d     = 1'b1;
      found_key_d = decrypt_key_q;
    end

    exhausted_d = exhausted_q;
    if (go_clear) exhausted_d = 1'b0;
    else if (state_d == S_EXHAUSTED && state_q != S_EXHAUSTED) exhausted_d = 1'b1;

    attempts_d = attempts_q;
    if (go_clear) attempts_d = '0;
    else if (dec_end && attempts_q != '1) attempts_d = attempts_q + 1'b1;

`ifdef KEY_SEARCH_TIMEOUT_EN
    // counts cycles since decrypt_start, so LAUNCH seeds it with 1
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_LAUNCH)        tmo_cnt_d = CNT_W'(1);
    else if (state_q == S_WAIT_DEC) tmo_cnt_d = tmo_cnt_q + 1'b1;
    timeout_err_d = timeout_err_q || (state_d == S_ERROR);
`endif
  end

  assign key_req       = key_req_q;
  assign decrypt_start = decrypt_start_q;
  assign decrypt_key   = decrypt_key_q;
  assign busy          = busy_q;
  assign found         = found_q;
  assign found_key     = found_key_q;
  assign exhausted     = exhausted_q;
  assign attempts      = attempts_q;
`ifdef KEY_SEARCH_TIMEOUT_EN
  assign timeout_err   = timeout_err_q;
`endif

endmodule

`default_nettype wire
